// File: rtl/fifo_rd_pkg.sv
// Shared definitions for the FIFO burst reader: controller state encoding,
// default parameter values and the WAIT timeout used when FIFO_RD_TIMEOUT_EN is defined.
package fifo_rd_pkg;

    localparam int unsigned DefDataW    = 32;
    localparam int unsigned DefLenW     = 5;
    localparam int unsigned DefRetryGap = 2;
    localparam int unsigned DefMaxRetry = 15;
    // Cycles a read may wait for any FIFO response before the burst is abandoned.
    localparam int unsigned WaitTimeout = 16;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWait,
        StOut,
        StBackoff
    } rd_state_e;

endpackage

// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: pops a burst of cmd_len words from the synchronous FIFO one at a time
// and forwards them on a valid/ready stream. An empty-FIFO response (rd_err) backs off for
// RETRY_GAP cycles and re-issues the same read.
// Optional macro FIFO_RD_TIMEOUT_EN: bounds consecutive retries to MAX_RETRY and WAIT time
// to WaitTimeout cycles; either limit ends the burst with an abort pulse.
module fifo_burst_reader
    import fifo_rd_pkg::*;
#(
    parameter int unsigned DATA_W    = DefDataW,
    parameter int unsigned LEN_W     = DefLenW,
`ifdef FIFO_RD_TIMEOUT_EN
    parameter int unsigned MAX_RETRY = DefMaxRetry,
`endif
    parameter int unsigned RETRY_GAP = DefRetryGap
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    input  logic [LEN_W-1:0]  cmd_len,
    output logic              cmd_ready,
    output logic              rd_en,
    input  logic [DATA_W-1:0] dout,
    input  logic              rd_ack,
    input  logic              rd_err,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    input  logic              m_ready,
    output logic              done,
    output logic              abort,
    output logic [LEN_W-1:0]  words_left
);

    localparam int unsigned GapW = (RETRY_GAP > 1) ? $clog2(RETRY_GAP) : 1;
    localparam logic [GapW-1:0] GapLast = GapW'(RETRY_GAP - 1);

    rd_state_e         state_q, state_d;
    logic [LEN_W-1:0]  words_left_q, words_left_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [GapW-1:0]   gap_q, gap_d;
    logic              done_q, done_d;

`ifdef FIFO_RD_TIMEOUT_EN
    localparam int unsigned RetryW = $clog2(MAX_RETRY + 1);
    localparam int unsigned WaitW  = $clog2(WaitTimeout);
    localparam logic [RetryW-1:0] RetryMax = RetryW'(MAX_RETRY);
    localparam logic [WaitW-1:0]  WaitLast = WaitW'(WaitTimeout - 1);

    logic [RetryW-1:0] retry_q, retry_d, retry_inc;
    logic [WaitW-1:0]  wait_q, wait_d;
    logic              abort_q, abort_d;

    // Saturating increment of the consecutive-error count.
    assign retry_inc = (retry_q == RetryMax) ? retry_q : retry_q + RetryW'(1);
`endif

    // Next-state logic: one read outstanding at a time, output register held until handshake.
    always_comb begin
        state_d      = state_q;
        words_left_d = words_left_q;
        data_d       = data_q;
        gap_d        = gap_q;
        done_d       = 1'b0;
`ifdef FIFO_RD_TIMEOUT_EN
        retry_d      = retry_q;
        wait_d       = wait_q;
        abort_d      = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    if (cmd_len != '0) begin
                        state_d      = StReq;
                        words_left_d = cmd_len;
`ifdef FIFO_RD_TIMEOUT_EN
                        retry_d      = '0;
`endif
                    end else begin
                        // Empty burst completes immediately without touching the FIFO.
                        done_d = 1'b1;
                    end
                end
            end
            StReq: begin
                state_d = StWait;
`ifdef FIFO_RD_TIMEOUT_EN
                wait_d  = '0;
`endif
            end
            StWait: begin
                // rd_ack has priority: a word delivered is a word consumed.
                if (rd_ack) begin
                    data_d  = dout;
                    state_d = StOut;
`ifdef FIFO_RD_TIMEOUT_EN
                    retry_d = '0;
`endif
                end else if (rd_err) begin
`ifdef FIFO_RD_TIMEOUT_EN
                    retry_d = retry_inc;
                    if (retry_inc == RetryMax) begin
                        state_d      = StIdle;
                        words_left_d = '0;
                        abort_d      = 1'b1;
                    end else begin
                        state_d = StBackoff;
                        gap_d   = '0;
                    end
`else
                    state_d = StBackoff;
                    gap_d   = '0;
`endif
                end
`ifdef FIFO_RD_TIMEOUT_EN
                else if (wait_q == WaitLast) begin
                    state_d      = StIdle;
                    words_left_d = '0;
                    abort_d      = 1'b1;
                end else begin
                    wait_d = wait_q + WaitW'(1);
                end
`endif
            end
            StOut: begin
                if (m_ready) begin
                    words_left_d = words_left_q - LEN_W'(1);
                    if (words_left_q == LEN_W'(1)) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end else begin
                        state_d = StReq;
                    end
                end
            end
            StBackoff: begin
                if (gap_q == GapLast) begin
                    state_d = StReq;
                end else begin
                    gap_d = gap_q + GapW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            words_left_q <= '0;
            data_q       <= '0;
            gap_q        <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            words_left_q <= words_left_d;
            data_q       <= data_d;
            gap_q        <= gap_d;
            done_q       <= done_d;
        end
    end

`ifdef FIFO_RD_TIMEOUT_EN
    // Retry and WAIT-timeout counters, present only when the bounds are enabled.
    always_ff @(posedge clk) begin
        if (reset) begin
            retry_q <= '0;
            wait_q  <= '0;
            abort_q <= 1'b0;
        end else begin
            retry_q <= retry_d;
            wait_q  <= wait_d;
            abort_q <= abort_d;
        end
    end

    assign abort = abort_q;
`else
    assign abort = 1'b0;
`endif

    assign cmd_ready  = (state_q == StIdle);
    assign rd_en      = (state_q == StReq);
    assign m_valid    = (state_q == StOut);
    assign m_data     = data_q;
    assign m_last     = (state_q == StOut) && (words_left_q == LEN_W'(1));
    assign done       = done_q;
    assign words_left = words_left_q;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Self-checking bench for fifo_burst_reader: a queue-based FIFO responder, a stream monitor,
// and directed plus randomized bursts compared against expectations derived from the
// burst rules (in-order words, 3-cycle cadence, RETRY_GAP+1 back-off, done timing).
module tb_fifo_burst_reader;

    localparam int unsigned DataW    = 32;
    localparam int unsigned LenW     = 5;
    localparam int unsigned RetryGap = 2;
    localparam int unsigned MaxRetry = 15;

    typedef logic [DataW-1:0] word_q_t[$];

    logic             clk = 1'b0;
    logic             reset;
    logic             cmd_valid;
    logic [LenW-1:0]  cmd_len;
    logic             cmd_ready;
    logic             rd_en;
    logic [DataW-1:0] dout;
    logic             rd_ack;
    logic             rd_err;
    logic             m_valid;
    logic [DataW-1:0] m_data;
    logic             m_last;
    logic             m_ready;
    logic             done;
    logic             abort;
    logic [LenW-1:0]  words_left;

    fifo_burst_reader dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_len    (cmd_len),
        .cmd_ready  (cmd_ready),
        .rd_en      (rd_en),
        .dout       (dout),
        .rd_ack     (rd_ack),
        .rd_err     (rd_err),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .m_last     (m_last),
        .m_ready    (m_ready),
        .done       (done),
        .abort      (abort),
        .words_left (words_left)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // Bench control (written only by the main sequence).
    int ready_mode = 0;  // 0 high, 1 stall every second word, 2 random, 3 low
    bit force_both = 1'b0;
    bit inject_ack = 1'b0;
    bit clear_req  = 1'b0;

    // FIFO contents and monitor logs.
    word_q_t          fifo_q;
    word_q_t          got_data;
    bit               got_last[$];
    int               got_wl[$];
    int               rd_en_cyc[$];
    int               err_cyc[$];
    int               done_cyc[$];
    int               abort_cnt = 0;
    int               valid_cnt = 0;
    int               stab_err  = 0;
    int               stall_rd  = 0;
    bit               pend      = 1'b0;
    bit               prev_stall = 1'b0;
    logic [DataW-1:0] prev_data;
    logic             prev_last;

    // Monitor: samples the DUT mid-cycle and records every event of interest.
    always @(negedge clk) begin
        if (clear_req) begin
            got_data.delete();
            got_last.delete();
            got_wl.delete();
            rd_en_cyc.delete();
            err_cyc.delete();
            done_cyc.delete();
            abort_cnt = 0;
            valid_cnt = 0;
            stab_err  = 0;
            stall_rd  = 0;
        end
        pend = rd_en;
        if (rd_en) rd_en_cyc.push_back(cyc);
        if (rd_err) err_cyc.push_back(cyc);
        if (done) done_cyc.push_back(cyc);
        if (abort) abort_cnt++;
        if (m_valid) begin
            valid_cnt++;
            if (prev_stall && (m_data !== prev_data || m_last !== prev_last)) stab_err++;
            if (!m_ready && rd_en) stall_rd++;
            if (m_ready) begin
                got_data.push_back(m_data);
                got_last.push_back(m_last);
                got_wl.push_back(int'(words_left));
            end
            prev_stall = !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end else begin
            prev_stall = 1'b0;
        end
    end

    // FIFO responder: answers a pop one cycle later with a word or an empty error.
    initial begin : fifo_model
        rd_ack = 1'b0;
        rd_err = 1'b0;
        dout   = '0;
        forever begin
            @(posedge clk);
            #1;
            rd_ack = 1'b0;
            rd_err = 1'b0;
            if (inject_ack) begin
                rd_ack = 1'b1;
                dout   = 32'hDEAD_BEEF;
            end else if (pend) begin
                if (fifo_q.size() > 0) begin
                    dout   = fifo_q.pop_front();
                    rd_ack = 1'b1;
                    rd_err = force_both;
                end else begin
                    rd_err = 1'b1;
                end
            end
        end
    end

    // Downstream ready generator.
    initial begin : ready_driver
        bit word_seen;
        word_seen = 1'b0;
        m_ready   = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1: begin
                    m_ready = 1'b1;
                    if (m_valid && !word_seen) begin
                        word_seen = 1'b1;
                        if (got_data.size() % 2 == 1) begin
                            m_ready = 1'b0;
                            repeat (4) begin
                                @(posedge clk);
                                #1;
                            end
                            m_ready = 1'b1;
                        end
                    end
                    if (!m_valid) word_seen = 1'b0;
                end
                2: m_ready = 1'($urandom_range(0, 1));
                3: m_ready = 1'b0;
                default: m_ready = 1'b1;
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_logs();
        clear_req = 1'b1;
        @(negedge clk);
        #1;
        clear_req = 1'b0;
    endtask

    task automatic send_cmd(input int len, output int acc);
        tick();
        check("cmd_ready_before_cmd", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_len   = LenW'(len);
        tick();
        cmd_valid = 1'b0;
        acc       = cyc;
    endtask

    task automatic wait_end(input int budget, output bit ok);
        for (int i = 0; i < budget; i++) begin
            if (done_cyc.size() > 0 || abort_cnt > 0) break;
            tick();
        end
        ok = (done_cyc.size() > 0 || abort_cnt > 0);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_cmd_ready"}, cmd_ready, 1);
        check({tag, "_rd_en"}, rd_en, 0);
        check({tag, "_m_valid"}, m_valid, 0);
        check({tag, "_m_data"}, m_data, 0);
        check({tag, "_m_last"}, m_last, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_abort"}, abort, 0);
        check({tag, "_words_left"}, words_left, 0);
    endtask

    // Expected stream: the words in FIFO order, last flag on the final one,
    // words still owed counting down to 1, and exactly one done.
    task automatic check_stream(input string tag, input word_q_t exp);
        check({tag, "_n_words"}, got_data.size(), exp.size());
        for (int i = 0; i < exp.size(); i++) begin
            check({tag, "_data"}, got_data[i], exp[i]);
            check({tag, "_last"}, got_last[i], (i == exp.size() - 1) ? 1 : 0);
            check({tag, "_wleft"}, got_wl[i], exp.size() - i);
        end
        check({tag, "_done_cnt"}, done_cyc.size(), 1);
    endtask

    initial begin : main
        int      acc;
        bit      ok;
        word_q_t exp;
        int      n;
        logic [DataW-1:0] w;

        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_len   = '0;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        check_idle("reset");

        // Seven preloaded words at full throughput.
        clear_logs();
        exp.delete();
        for (int i = 1; i <= 7; i++) begin
            fifo_q.push_back(DataW'(i));
            exp.push_back(DataW'(i));
        end
        send_cmd(7, acc);
        wait_end(200, ok);
        check("t1_completes", ok, 1);
        tick();
        tick();
        check("t1_rd_en_cnt", rd_en_cyc.size(), 7);
        for (int i = 0; i < 7; i++) check("t1_rd_en_cadence", rd_en_cyc[i], acc + 3 * i);
        check_stream("t1", exp);
        check("t1_done_cycle", done_cyc[0], acc + 3 * 7);
        check("t1_fifo_empty", fifo_q.size(), 0);
        check("t1_words_left", words_left, 0);

        // Twelve words with a 4-cycle stall on every second word.
        clear_logs();
        exp.delete();
        for (int i = 8; i <= 19; i++) begin
            fifo_q.push_back(DataW'(i));
            exp.push_back(DataW'(i));
        end
        ready_mode = 1;
        send_cmd(12, acc);
        wait_end(400, ok);
        check("t2_completes", ok, 1);
        tick();
        ready_mode = 0;
        check_stream("t2", exp);
        check("t2_held_stable", stab_err, 0);
        check("t2_no_rd_en_in_stall", stall_rd, 0);
        check("t2_valid_cycles", valid_cnt, 12 + 4 * (12 / 2));
        check("t2_words_left", words_left, 0);

        // Empty FIFO: three errors, then two words become available.
        clear_logs();
        send_cmd(2, acc);
        for (int i = 0; i < 100; i++) begin
            if (err_cyc.size() >= 3) break;
            tick();
        end
        check("t3_three_errors", err_cyc.size(), 3);
        fifo_q.push_back(32'hA);
        fifo_q.push_back(32'hB);
        wait_end(200, ok);
        check("t3_completes", ok, 1);
        tick();
        check("t3_rd_en_cnt", rd_en_cyc.size(), 5);
        for (int i = 0; i < 3; i++) begin
            check("t3_retry_gap", rd_en_cyc[i + 1] - err_cyc[i], RetryGap + 1);
        end
        exp.delete();
        exp.push_back(32'hA);
        exp.push_back(32'hB);
        check_stream("t3", exp);

        // FIFO that never fills.
        clear_logs();
        send_cmd(1, acc);
`ifdef FIFO_RD_TIMEOUT_EN
        wait_end(400, ok);
        check("t4_aborts", ok, 1);
        tick();
        check("t4_abort_cnt", abort_cnt, 1);
        check("t4_err_cnt", err_cyc.size(), MaxRetry);
        check("t4_no_done", done_cyc.size(), 0);
        check("t4_no_valid", valid_cnt, 0);
        check("t4_idle", cmd_ready, 1);
        check("t4_words_left", words_left, 0);
`else
        repeat (200) tick();
        check("t4_no_done", done_cyc.size(), 0);
        check("t4_no_abort", abort_cnt, 0);
        check("t4_no_valid", valid_cnt, 0);
        check("t4_still_busy", cmd_ready, 0);
        check("t4_still_retrying", (err_cyc.size() >= 200 / (RetryGap + 2) - 5) ? 1 : 0, 1);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_idle("t4_reset");
`endif

        // Zero-length command: done next cycle, FIFO untouched.
        clear_logs();
        send_cmd(0, acc);
        check("t5_done_now", done, 1);
        check("t5_ready_now", cmd_ready, 1);
        repeat (3) tick();
        check("t5_done_cnt", done_cyc.size(), 1);
        check("t5_done_cycle", done_cyc[0], acc);
        check("t5_no_rd_en", rd_en_cyc.size(), 0);

        // rd_ack and rd_err together: the word is taken.
        clear_logs();
        w = $urandom;
        fifo_q.push_back(w);
        force_both = 1'b1;
        send_cmd(1, acc);
        wait_end(100, ok);
        force_both = 1'b0;
        check("t5b_completes", ok, 1);
        tick();
        exp.delete();
        exp.push_back(w);
        check_stream("t5b", exp);
        check("t5b_single_read", rd_en_cyc.size(), 1);

        // Reset while a word is held in OUT, with a stray ack arriving afterwards.
        clear_logs();
        for (int i = 0; i < 5; i++) fifo_q.push_back($urandom | 32'h1);
        ready_mode = 3;
        send_cmd(5, acc);
        for (int i = 0; i < 20; i++) begin
            if (m_valid) break;
            tick();
        end
        check("t6_in_out", m_valid, 1);
        reset      = 1'b1;
        inject_ack = 1'b1;
        tick();
        reset      = 1'b0;
        inject_ack = 1'b0;
        ready_mode = 0;
        check_idle("t6_reset");
        tick();
        check("t6_stray_ignored_ready", cmd_ready, 1);
        check("t6_stray_ignored_valid", m_valid, 0);
        check("t6_stray_ignored_rd_en", rd_en, 0);
        fifo_q.delete();
        clear_logs();
        w = $urandom;
        fifo_q.push_back(w);
        send_cmd(1, acc);
        wait_end(100, ok);
        check("t6_new_burst", ok, 1);
        tick();
        exp.delete();
        exp.push_back(w);
        check_stream("t6", exp);

        // Randomized bursts with random back-pressure.
        for (int t = 0; t < 3; t++) begin
            clear_logs();
            n = $urandom_range(1, 12);
            exp.delete();
            for (int i = 0; i < n; i++) begin
                w = $urandom;
                fifo_q.push_back(w);
                exp.push_back(w);
            end
            ready_mode = 2;
            send_cmd(n, acc);
            wait_end(800, ok);
            check("t7_completes", ok, 1);
            tick();
            ready_mode = 0;
            check_stream("t7", exp);
            check("t7_held_stable", stab_err, 0);
            check("t7_fifo_empty", fifo_q.size(), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_burst_reader.md
# fifo_burst_reader

Read-side controller for the 32-bit synchronous FIFO in the arithmetic & logical computing system. On a burst command it pops up to `cmd_len` words one at a time over the FIFO's `rd_en`/`rd_ack`/`rd_err` port and forwards them on a valid/ready stream toward the ALU operand path. When the FIFO reports empty, it backs off and retries the same word.

## Interface
- `DATA_W`, 32, FIFO word and stream data width.
- `LEN_W`, 5, width of burst length and remaining-count fields.
- `RETRY_GAP`, 2, idle cycles between an `rd_err` and the re-issued read (≥1).
- `MAX_RETRY`, 15, consecutive `rd_err` responses tolerated before abort (used only with the macro).
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `cmd_valid` in 1: burst request.
- `cmd_len` in LEN_W: words to read, 0 to 2^LEN_W−1.
- `cmd_ready` out 1: high only in IDLE.
- `rd_en` out 1: FIFO pop request, one-cycle pulse.
- `dout` in DATA_W: FIFO read data, valid with `rd_ack`.
- `rd_ack` in 1: FIFO returned a word, one cycle after `rd_en`.
- `rd_err` in 1: FIFO empty, one cycle after `rd_en`.
- `m_valid` out 1, `m_data` out DATA_W, `m_last` out 1, `m_ready` in 1: downstream stream.
- `done` out 1: one-cycle pulse when the burst completes.
- `abort` out 1: one-cycle pulse on retry exhaustion (macro only).
- `words_left` out LEN_W: words still owed in the current burst.

## Operation
- States:
  - IDLE → REQ on `cmd_valid`, when `cmd_len`≠0. Latch `words_left`=`cmd_len`; clear the retry count.
  - IDLE → IDLE on `cmd_len`=0. Pulse `done` the next cycle; `rd_en` is never raised.
  - REQ: `rd_en`=1 for exactly one cycle → WAIT.
  - WAIT on `rd_ack`: capture `dout` into the output register; clear the retry count → OUT.
  - WAIT on `rd_err` only: increment the retry count → BACKOFF.
  - WAIT with neither response: stay in WAIT.
  - `rd_ack` and `rd_err` together: `rd_ack` wins; `rd_err` is ignored.
  - OUT: `m_valid`=1. `m_data` and `m_last` stay stable until `m_ready`. On handshake, decrement `words_left`. Go to IDLE if it reaches 0 (pulse `done`), else REQ.
  - BACKOFF: count RETRY_GAP cycles → REQ.
- `m_last`=1 iff `words_left`=1 while in OUT.
- `rd_ack` and `rd_err` are ignored in every state except WAIT.
- At most one read is outstanding; no FIFO underflow or overflow is possible from this block.
- Counters are unsigned. `words_left` never wraps below 0. The retry count saturates at MAX_RETRY.

## Timing
- Reset values: state IDLE; `cmd_ready`=1; `rd_en`=0; `m_valid`=0; `m_data`=0; `m_last`=0; `done`=0; `abort`=0; `words_left`=0.
- Command accepted at edge T → `rd_en` high in cycle T+1 → FIFO response sampled at edge T+2 → `m_valid` high from cycle T+2 (after that edge).
- Steady state with `m_ready` held high: one word per 3 cycles (REQ, WAIT, OUT).
- A `m_ready` stall holds OUT indefinitely; no new `rd_en` is issued meanwhile.
- Each `rd_err` adds 1 + RETRY_GAP cycles before the re-issued `rd_en`.
- `done` asserts in the cycle after the final handshake, together with `cmd_ready`=1.
- Reset mid-burst:
  - All state clears at that edge; `rd_en` is low the next cycle.
  - A word popped but not yet forwarded is discarded; this is accepted behaviour.
  - A late `rd_ack` arriving in IDLE is ignored.

## Configuration
- `FIFO_RD_TIMEOUT_EN` defined:
  - When the retry count reaches MAX_RETRY on an `rd_err`, go to IDLE instead of BACKOFF.
  - Pulse `abort` (not `done`) and set `words_left` to 0.
  - A WAIT with no response for 16 cycles also aborts.
- `FIFO_RD_TIMEOUT_EN` undefined:
  - Retries are unbounded and WAIT may last forever.
  - `abort` is tied 0.
  - The retry counter and timeout logic are not synthesized.

## Structure
- Shared package `fifo_rd_pkg`: state enum (IDLE, REQ, WAIT, OUT, BACKOFF), default DATA_W/LEN_W/RETRY_GAP/MAX_RETRY constants, and the 16-cycle WAIT timeout constant.
- Single module; the logic is one FSM plus three counters, so no sub-module is warranted.

## Test plan
- Preload FIFO with 0x1–0x7; command `cmd_len`=7 with `m_ready`=1:
  - Exactly 7 `rd_en` pulses, 3 cycles apart.
  - Stream carries 0x1..0x7; `m_last` is high only on 0x7.
  - `done` pulses once; FIFO ends empty.
- Preload 0x8–0x13 (12 words); `cmd_len`=12; `m_ready` low for 4 cycles on every second word:
  - Data stays held while stalled; no `rd_en` is issued during a stall.
  - Order is preserved and `words_left` counts 12→0.
- Empty FIFO, `cmd_len`=2; push 0xA after 3 `rd_err` responses, then 0xB:
  - Re-issued `rd_en` comes RETRY_GAP+1 cycles after each error.
  - Stream delivers 0xA then 0xB, followed by `done`.
- Empty FIFO held forever, `cmd_len`=1:
  - With the macro: `abort` after 15 errors, no `m_valid`, returns to IDLE.
  - Without the macro: still retrying after 200 cycles.
- `cmd_len`=0 → `done` the next cycle and no `rd_en`. Then force `rd_ack` and `rd_err` together in WAIT → word accepted as data.
- Assert `reset` for 1 cycle while in OUT of a 5-word burst:
  - Next cycle all outputs are at reset values; a stray `rd_ack` is ignored.
  - A new `cmd_len`=1 burst then completes normally.
